// File: rtl/multi_lane_align_ctrl.sv
// Multi-lane aligner job dispatcher and result collector.
// Steers host query streams to free lanes in round-robin order and gathers
// each lane's unstallable traceback output into a per-lane FIFO, then returns
// whole alignments, tagged with their lane, on one ready/valid stream.
module multi_lane_align_ctrl #(
  parameter int NUM_LANES  = 4,
  parameter int LANE_W     = 2,
  parameter int BP_WIDTH   = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_i,
  input  logic                          host_valid,
  output logic                          host_ready,
  input  logic                          host_new_seq,
  input  logic                          host_last,
  input  logic [BP_WIDTH-1:0]           host_T,
  output logic [NUM_LANES-1:0]          lane_valid,
  output logic [NUM_LANES-1:0]          lane_new_seq,
  output logic [BP_WIDTH-1:0]           lane_T,
  input  logic [NUM_LANES-1:0]          lane_busy,
  input  logic [NUM_LANES-1:0]          lane_aln_valid,
  input  logic [NUM_LANES*BP_WIDTH-1:0] lane_aln_out,
  input  logic [NUM_LANES-1:0]          lane_done,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BP_WIDTH-1:0]           out_bp,
  output logic [LANE_W-1:0]             out_lane,
  output logic                          out_last,
  output logic                          out_null,
  output logic [NUM_LANES-1:0]          lane_idle,
  output logic                          err_proto,
  output logic [NUM_LANES-1:0]          err_overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = BP_WIDTH + 2;  // {last, null, bp}

  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_RUN} lane_state_e;
  typedef enum logic       {D_SEL, D_STREAM}       disp_state_e;

  function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] l);
    return (int'(l) == NUM_LANES - 1) ? '0 : l + 1'b1;
  endfunction

  lane_state_e          lane_st_q [NUM_LANES];
  lane_state_e          lane_st_d [NUM_LANES];
  disp_state_e          d_st_q, d_st_d;
  logic [LANE_W-1:0]    sel_q, sel_d, rr_ptr_q, rr_ptr_d;
  logic                 err_proto_q, err_proto_d;
  logic [NUM_LANES-1:0] err_ovf_q, err_ovf_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [LANE_W-1:0]    grant_q, grant_d, arb_ptr_q, arb_ptr_d;

  logic [ENTRY_W-1:0]   mem_q    [NUM_LANES][FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr_q [NUM_LANES];
  logic [PTR_W:0]       wr_ptr_d [NUM_LANES];
  logic [PTR_W:0]       rd_ptr_q [NUM_LANES];
  logic [PTR_W:0]       rd_ptr_d [NUM_LANES];
  logic [ENTRY_W-1:0]   wr_entry [NUM_LANES];
  logic [NUM_LANES-1:0] fifo_empty, fifo_full, fifo_wr, fifo_rd;

  logic                 start_job, last_acc, pick_found, cand_found, pop;
  logic [LANE_W-1:0]    pick, cand, cur_lane;
  logic [ENTRY_W-1:0]   head;

  assign lane_T       = host_T;
  assign err_proto    = err_proto_q;
  assign err_overflow = err_ovf_q;

  // Dispatcher: choose a free lane for a new job, then forward beats to it.
  // NOTE: every signal gets a default at the top of a combinational block so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    d_st_d       = d_st_q;
    sel_d        = sel_q;
    rr_ptr_d     = rr_ptr_q;
    err_proto_d  = err_proto_q;
    host_ready   = 1'b0;
    lane_valid   = '0;
    lane_new_seq = '0;
    start_job    = 1'b0;
    last_acc     = 1'b0;
    pick_found   = 1'b0;
    pick         = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_LANES;
      if (!pick_found && lane_st_q[idx] == L_IDLE) begin
        pick_found = 1'b1;
        pick       = LANE_W'(idx);
      end
    end
    case (d_st_q)
      D_SEL: begin
        if (host_valid && host_new_seq) begin
          // The first beat waits here one cycle; it is accepted in D_STREAM.
          if (pick_found) begin
            sel_d     = pick;
            d_st_d    = D_STREAM;
            start_job = 1'b1;
          end
        end else if (host_valid) begin
          host_ready  = 1'b1;
          err_proto_d = 1'b1;
        end
      end
      default: begin
        host_ready = !lane_busy[sel_q];
        if (host_valid && host_ready) begin
          lane_valid[sel_q]   = 1'b1;
          lane_new_seq[sel_q] = host_new_seq;
          if (host_last) begin
            last_acc = 1'b1;
            rr_ptr_d = next_lane(sel_q);
            d_st_d   = D_SEL;
          end
        end
      end
    endcase
  end

  // Per-lane job state: IDLE -> LOAD on dispatch, RUN after the last beat.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_st_d[i] = lane_st_q[i];
      lane_idle[i] = (lane_st_q[i] == L_IDLE);
      case (lane_st_q[i])
        L_IDLE:  if (start_job && pick == LANE_W'(i)) lane_st_d[i] = L_LOAD;
        L_LOAD:  if (last_acc && sel_q == LANE_W'(i)) lane_st_d[i] = L_RUN;
        default: if (lane_done[i])                    lane_st_d[i] = L_IDLE;
      endcase
    end
  end

  // FIFO occupancy flags from the wrap-bit pointer pair.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      fifo_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      fifo_full[i]  = (wr_ptr_q[i][PTR_W] != rd_ptr_q[i][PTR_W]) &&
                      (wr_ptr_q[i][PTR_W-1:0] == rd_ptr_q[i][PTR_W-1:0]);
    end
  end

  // Output arbiter: the presented lane is held until its last entry pops,
  // so an alignment stays contiguous and out_* stays stable under stall.
  always_comb begin
    grant_valid_d = grant_valid_q;
    grant_d       = grant_q;
    arb_ptr_d     = arb_ptr_q;
    cand_found    = 1'b0;
    cand          = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      int idx;
      idx = (int'(arb_ptr_q) + k) % NUM_LANES;
      if (!cand_found && !fifo_empty[idx]) begin
        cand_found = 1'b1;
        cand       = LANE_W'(idx);
      end
    end
    cur_lane  = grant_valid_q ? grant_q : cand;
    out_valid = grant_valid_q ? !fifo_empty[grant_q] : cand_found;
    head      = mem_q[cur_lane][rd_ptr_q[cur_lane][PTR_W-1:0]];
    pop       = out_valid && out_ready;
    out_bp    = out_valid ? head[BP_WIDTH-1:0] : '0;
    out_lane  = out_valid ? cur_lane : '0;
    out_last  = out_valid && head[ENTRY_W-1];
    out_null  = out_valid && head[ENTRY_W-2];
    if (out_valid) begin
      if (pop && head[ENTRY_W-1]) begin
        grant_valid_d = 1'b0;
        arb_ptr_d     = next_lane(cur_lane);
      end else begin
        grant_valid_d = 1'b1;
        grant_d       = cur_lane;
      end
    end
  end

  // FIFO write/read control; a pop on a full FIFO frees room for this write.
  always_comb begin
    err_ovf_d = err_ovf_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      wr_entry[i] = {lane_done[i], lane_done[i] && !lane_aln_valid[i],
                     lane_aln_valid[i] ? lane_aln_out[i*BP_WIDTH +: BP_WIDTH]
                                       : {BP_WIDTH{1'b0}}};
      fifo_rd[i]  = pop && (cur_lane == LANE_W'(i));
      fifo_wr[i]  = (lane_aln_valid[i] || lane_done[i]) &&
                    (!fifo_full[i] || fifo_rd[i]);
      if ((lane_aln_valid[i] || lane_done[i]) && fifo_full[i] && !fifo_rd[i])
        err_ovf_d[i] = 1'b1;
      wr_ptr_d[i] = fifo_wr[i] ? wr_ptr_q[i] + 1'b1 : wr_ptr_q[i];
      rd_ptr_d[i] = fifo_rd[i] ? rd_ptr_q[i] + 1'b1 : rd_ptr_q[i];
    end
  end

  // FIFO storage.
  // NOTE: the entry array has no reset; pointers define validity, and
  // leaving data flops unreset keeps them plain RAM-friendly registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      if (fifo_wr[i]) mem_q[i][wr_ptr_q[i][PTR_W-1:0]] <= wr_entry[i];
  end

  // Control state registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      d_st_q        <= D_SEL;
      sel_q         <= '0;
      rr_ptr_q      <= '0;
      err_proto_q   <= 1'b0;
      err_ovf_q     <= '0;
      grant_valid_q <= 1'b0;
      grant_q       <= '0;
      arb_ptr_q     <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_st_q[i] <= L_IDLE;
        wr_ptr_q[i]  <= '0;
        rd_ptr_q[i]  <= '0;
      end
    end else begin
      d_st_q        <= d_st_d;
      sel_q         <= sel_d;
      rr_ptr_q      <= rr_ptr_d;
      err_proto_q   <= err_proto_d;
      err_ovf_q     <= err_ovf_d;
      grant_valid_q <= grant_valid_d;
      grant_q       <= grant_d;
      arb_ptr_q     <= arb_ptr_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_st_q[i] <= lane_st_d[i];
        wr_ptr_q[i]  <= wr_ptr_d[i];
        rd_ptr_q[i]  <= rd_ptr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_lane_align_ctrl.sv
// Self-checking bench for multi_lane_align_ctrl: a queue-based model of
// dispatch and result collection checked every cycle, plus directed scenarios
// with hand-computed expectations.
module tb_multi_lane_align_ctrl;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       host_valid, host_ready, host_new_seq, host_last;
  logic [1:0] host_T, lane_T;
  logic [3:0] lane_valid, lane_new_seq, lane_busy, lane_aln_valid, lane_done;
  logic [7:0] lane_aln_out;
  logic       out_valid, out_ready, out_last, out_null;
  logic [1:0] out_bp, out_lane;
  logic [3:0] lane_idle, err_overflow;
  logic       err_proto;

  multi_lane_align_ctrl #(.NUM_LANES(4), .LANE_W(2), .BP_WIDTH(2), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset_i(reset_i),
    .host_valid(host_valid), .host_ready(host_ready), .host_new_seq(host_new_seq),
    .host_last(host_last), .host_T(host_T),
    .lane_valid(lane_valid), .lane_new_seq(lane_new_seq), .lane_T(lane_T),
    .lane_busy(lane_busy), .lane_aln_valid(lane_aln_valid), .lane_aln_out(lane_aln_out),
    .lane_done(lane_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_bp(out_bp), .out_lane(out_lane),
    .out_last(out_last), .out_null(out_null),
    .lane_idle(lane_idle), .err_proto(err_proto), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {logic last; logic nul; logic [1:0] bp;} ent_t;
  typedef struct {int lane; bit last; bit nul; int bp;} rec_t;

  bit   m_idle [4];
  bit   m_run  [4];
  bit   m_inflight, m_errp, m_held;
  bit   [3:0] m_ovf;
  int   m_sel, m_rr, m_arb, m_grant;
  ent_t m_q [4][$];

  rec_t pops[$];
  int   disp_q[$];
  int   vcount[4];
  int   ncount[4];

  // First idle lane in round-robin order from the pointer, -1 if none.
  function automatic int pick_lane();
    for (int k = 0; k < 4; k++)
      if (m_idle[(m_rr + k) % 4]) return (m_rr + k) % 4;
    return -1;
  endfunction

  // Lane whose head entry is on the output this cycle, -1 if nothing shown.
  function automatic int arb_lane();
    if (m_held) return (m_q[m_grant].size() > 0) ? m_grant : -1;
    for (int k = 0; k < 4; k++)
      if (m_q[(m_arb + k) % 4].size() > 0) return (m_arb + k) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin : mdl
    int   al, p;
    ent_t e;
    if (reset_i) begin
      for (int i = 0; i < 4; i++) begin
        m_idle[i] = 1'b1; m_run[i] = 1'b0; m_q[i].delete();
      end
      m_inflight = 0; m_errp = 0; m_held = 0; m_ovf = '0;
      m_sel = 0; m_rr = 0; m_arb = 0; m_grant = 0;
    end else begin
      al = arb_lane();
      p  = pick_lane();
      if (al >= 0) begin
        if (out_ready) begin
          e = m_q[al].pop_front();
          if (e.last) begin m_held = 0; m_arb = (al + 1) % 4; end
          else begin m_held = 1; m_grant = al; end
        end else begin
          m_held = 1; m_grant = al;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (lane_aln_valid[i] || lane_done[i]) begin
          e.last = lane_done[i];
          e.nul  = !lane_aln_valid[i];
          e.bp   = lane_aln_valid[i] ? lane_aln_out[i*2 +: 2] : 2'b00;
          if (m_q[i].size() < 16) m_q[i].push_back(e);
          else m_ovf[i] = 1'b1;
        end
        if (m_run[i] && lane_done[i]) begin m_run[i] = 0; m_idle[i] = 1; end
      end
      if (m_inflight) begin
        if (host_valid && !lane_busy[m_sel] && host_last) begin
          m_run[m_sel] = 1; m_inflight = 0; m_rr = (m_sel + 1) % 4;
        end
      end else if (host_valid && host_new_seq) begin
        if (p >= 0) begin m_inflight = 1; m_sel = p; m_idle[p] = 0; end
      end else if (host_valid) begin
        m_errp = 1;
      end
    end
  end

  // Compare DUT outputs against the model once per cycle, away from the edge.
  always @(negedge clk) begin : cmp
    int         al;
    logic       e_ready;
    logic [3:0] e_lv, e_idle;
    ent_t       h;
    if (!reset_i) begin
      e_ready = m_inflight ? !lane_busy[m_sel] : (host_valid && !host_new_seq);
      e_lv    = (m_inflight && host_valid && e_ready) ? 4'(1 << m_sel) : 4'b0000;
      for (int i = 0; i < 4; i++) e_idle[i] = m_idle[i];
      check("host_ready", host_ready, e_ready);
      check("lane_valid", lane_valid, e_lv);
      check("lane_new_seq", lane_new_seq, host_new_seq ? e_lv : 4'b0000);
      check("lane_T", lane_T, host_T);
      check("lane_idle", lane_idle, e_idle);
      check("err_proto", err_proto, m_errp);
      check("err_overflow", err_overflow, m_ovf);
      al = arb_lane();
      check("out_valid", out_valid, al >= 0);
      if (al >= 0 && out_valid) begin
        h = m_q[al][0];
        check("out_lane", out_lane, al);
        check("out_bp", out_bp, h.bp);
        check("out_last", out_last, h.last);
        check("out_null", out_null, h.nul);
      end
      for (int i = 0; i < 4; i++) begin
        if (lane_valid[i]) vcount[i]++;
        if (lane_new_seq[i]) begin ncount[i]++; disp_q.push_back(i); end
      end
      if (out_valid && out_ready)
        pops.push_back('{lane: int'(out_lane), last: out_last, nul: out_null, bp: int'(out_bp)});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    host_valid = 0; host_new_seq = 0; host_last = 0; host_T = '0;
    lane_busy = '0; lane_aln_valid = '0; lane_aln_out = '0; lane_done = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    reset_i = 1; tick(); reset_i = 0;
    pops.delete(); disp_q.delete();
    for (int i = 0; i < 4; i++) begin vcount[i] = 0; ncount[i] = 0; end
  endtask

  // Drive one job of nbeats; cycles counts the clocks it took.
  task automatic send_job(input int nbeats, output int cycles);
    int   b = 0;
    logic acc;
    cycles = 0;
    host_valid = 1;
    while (b < nbeats) begin
      host_new_seq = (b == 0);
      host_last    = (b == nbeats - 1);
      host_T       = 2'(b);
      @(negedge clk); acc = host_ready;
      @(posedge clk); #1;
      cycles++;
      if (acc) b++;
      if (cycles > 200) begin
        check("job_timeout", 1, 0);
        break;
      end
    end
    host_valid = 0; host_new_seq = 0; host_last = 0;
  endtask

  task automatic aln(input logic [3:0] v, input logic [7:0] d, input logic [3:0] dn);
    lane_aln_valid = v; lane_aln_out = d; lane_done = dn;
    tick();
    lane_aln_valid = '0; lane_done = '0;
  endtask

  initial begin
    int cyc;
    int exp_bp [8];
    int exp_disp [5];
    clear_inputs();
    out_ready = 1;
    reset_i = 1;
    tick(); tick();
    reset_i = 0;

    // Reset values
    @(negedge clk);
    check("rst_host_ready", host_ready, 0);
    check("rst_lane_idle", lane_idle, 4'hF);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_fields", {out_bp, out_lane, out_last, out_null}, 0);
    check("rst_errs", {err_proto, err_overflow}, 0);
    @(posedge clk); #1;

    // Single job to lane 0, then a 3-symbol traceback
    send_job(5, cyc);
    check("job1_cycles", cyc, 6);
    check("job1_strobes", vcount[0], 5);
    check("job1_newseq", ncount[0], 1);
    check("job1_idle", lane_idle, 4'b1110);
    aln(4'b0001, 8'h01, 4'b0000);
    aln(4'b0001, 8'h02, 4'b0000);
    aln(4'b0001, 8'h03, 4'b0001);
    repeat (4) tick();
    check("job1_pops", pops.size(), 3);
    for (int k = 0; k < 3 && k < pops.size(); k++) begin
      check("job1_lane", pops[k].lane, 0);
      check("job1_bp", pops[k].bp, k + 1);
      check("job1_last", pops[k].last, k == 2);
      check("job1_null", pops[k].nul, 0);
    end
    check("job1_idle_after", lane_idle, 4'hF);

    // Round robin, no free lane, wrap to the first freed lane
    reset_dut();
    repeat (4) send_job(2, cyc);
    fork
      send_job(3, cyc);
      begin
        repeat (3) tick();
        @(negedge clk);
        check("nofree_ready", host_ready, 0);
        check("nofree_idle", lane_idle, 4'b0000);
        @(posedge clk); #1;
        aln(4'b0000, 8'h00, 4'b0010);
      end
    join
    exp_disp = '{0, 1, 2, 3, 1};
    check("disp_count", disp_q.size(), 5);
    for (int k = 0; k < 5 && k < disp_q.size(); k++) check("disp_lane", disp_q[k], exp_disp[k]);
    check("term_lane", pops.size() > 0 ? pops[0].lane : 99, 1);
    check("term_flags", pops.size() > 0 ? {pops[0].last, pops[0].nul} : 2'b00, 2'b11);
    aln(4'b0000, 8'h00, 4'b1111);
    repeat (8) tick();
    check("rr_all_idle", lane_idle, 4'hF);

    // Simultaneous traceback from lanes 0 and 2
    reset_dut();
    for (int k = 0; k < 4; k++)
      aln(4'b0101, {2'b00, 2'(3 - k), 2'b00, 2'(k)}, (k == 3) ? 4'b0101 : 4'b0000);
    repeat (12) tick();
    exp_bp = '{0, 1, 2, 3, 3, 2, 1, 0};
    check("simul_pops", pops.size(), 8);
    for (int k = 0; k < 8 && k < pops.size(); k++) begin
      check("simul_lane", pops[k].lane, (k < 4) ? 0 : 2);
      check("simul_bp", pops[k].bp, exp_bp[k]);
      check("simul_last", pops[k].last, (k == 3) || (k == 7));
    end
    check("simul_errs", {err_proto, err_overflow}, 0);

    // Backpressure with overflow on lane 1
    reset_dut();
    out_ready = 0;
    for (int k = 0; k < 17; k++) aln(4'b0010, {4'b0000, 2'(k), 2'b00}, 4'b0000);
    @(negedge clk);
    check("ovf_flag", err_overflow, 4'b0010);
    check("ovf_hold_lane", out_lane, 1);
    check("ovf_hold_bp", out_bp, 0);
    @(posedge clk); #1;
    out_ready = 1;
    repeat (20) tick();
    check("ovf_drained", pops.size(), 16);
    check("ovf_last_bp", pops.size() == 16 ? pops[15].bp : 99, 3);

    // Full FIFO written and read in the same cycle: no drop
    reset_dut();
    out_ready = 0;
    for (int k = 0; k < 16; k++) aln(4'b1000, {2'(k), 6'b0}, 4'b0000);
    out_ready = 1;
    aln(4'b1000, 8'b10_000000, 4'b0000);
    repeat (20) tick();
    check("full_rw_ovf", err_overflow, 4'b0000);
    check("full_rw_pops", pops.size(), 17);
    check("full_rw_bp", pops.size() == 17 ? pops[16].bp : 99, 2);

    // Protocol error, busy stall, reset mid-stream
    reset_dut();
    host_valid = 1; host_new_seq = 0;
    @(negedge clk); check("proto_ready", host_ready, 1);
    @(posedge clk); #1;
    host_valid = 0;
    @(negedge clk);
    check("proto_err", err_proto, 1);
    check("proto_dropped", vcount[0] + vcount[1] + vcount[2] + vcount[3], 0);
    @(posedge clk); #1;
    host_valid = 1; host_new_seq = 1; host_T = 2'b11;
    tick();
    host_new_seq = 0; lane_busy = 4'b0001;
    @(negedge clk); check("busy_stall", host_ready, 0);
    @(posedge clk); #1;
    lane_busy = '0;
    tick(); tick();
    out_ready = 0;
    aln(4'b0001, 8'h01, 4'b0000);
    reset_i = 1; host_valid = 0; host_new_seq = 0;
    tick();
    reset_i = 0; out_ready = 1;
    @(negedge clk);
    check("mid_rst_ready", host_ready, 0);
    check("mid_rst_strobes", {lane_valid, lane_new_seq}, 0);
    check("mid_rst_out", {out_valid, out_bp, out_lane, out_last, out_null}, 0);
    check("mid_rst_idle", lane_idle, 4'hF);
    check("mid_rst_errs", {err_proto, err_overflow}, 0);
    @(posedge clk); #1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
